// File: rtl/gpu_wb_pkg.sv
// gpu_wb_pkg: shared widths, types and defaults for the GPU/DSP write-back
// controller (gpu_wback_ctl) and its pending-load queue (gpu_wb_ldq).
//   REG_AW        register address width {bank,reg}
//   REG_DW        register data width
//   LDQ_DEPTH_DEF default number of outstanding loads
package gpu_wb_pkg;

   localparam int unsigned REG_AW        = 6;
   localparam int unsigned REG_DW        = 32;
   localparam int unsigned LDQ_DEPTH_DEF = 2;
   localparam int unsigned SB_ENTRIES    = 1 << REG_AW;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/gpu_wb_ldq.sv
// gpu_wb_ldq: synchronous FIFO of pending load destination addresses.
// Ports:
//   clk, reset  clock, asynchronous active-high reset (empties the queue)
//   push, din   enqueue din; caller only asserts push when the slot is free
//               (not full, or a pop happens in the same cycle)
//   pop         dequeue head; caller only asserts pop when not empty
//   head        oldest entry (valid when !empty)
//   full, empty occupancy flags
module gpu_wb_ldq
   import gpu_wb_pkg::*;
#(
   parameter int unsigned DEPTH = LDQ_DEPTH_DEF
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  reg_addr_t din,
   input  logic      pop,
   output reg_addr_t head,
   output logic      full,
   output logic      empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   reg_addr_t     mem [DEPTH];

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + (PW+1)'(1);
         else if (pop && !push)
            count <= count - (PW+1)'(1);
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   // When full with push+pop, wr_ptr == rd_ptr: head is read before the edge
   // and the same slot is overwritten at it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/gpu_wback_ctl.sv
// gpu_wback_ctl: write-back controller for the GPU/DSP register file.
// ALU results leave on the dst write port, returning load data on the src
// write port. A 64-entry scoreboard of pending load targets drives hazard.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   alu_we/alu_wa/alu_wd ALU result (registered onto dst port next cycle)
//   ld_issue/ld_wa       load issued, destination recorded
//   mem_valid/mem_data   load data returning in issue order
//   q_srca/q_dsta        decode-stage register queries
//   hazard               pending load on q_srca or q_dsta (combinational)
//   ld_full              queue holds LDQ_DEPTH entries
//   err                  sticky overflow / underflow / double-pending issue
//   dsta/dstwd/dstrwen_n dst write port (enable active low)
//   srca/srcwd/srcrwen_n src write port (enable active low)
//   byp_hit/byp_data     only with GPU_WB_BYPASS_EN: returning load data
//                        forwarded to decode when head matches q_srca
// Configuration macro: GPU_WB_BYPASS_EN
module gpu_wback_ctl
   import gpu_wb_pkg::*;
#(
   parameter int unsigned LDQ_DEPTH = LDQ_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_we,
   input  logic [REG_AW-1:0] alu_wa,
   input  logic [REG_DW-1:0] alu_wd,
   input  logic              ld_issue,
   input  logic [REG_AW-1:0] ld_wa,
   input  logic              mem_valid,
   input  logic [REG_DW-1:0] mem_data,
   input  logic [REG_AW-1:0] q_srca,
   input  logic [REG_AW-1:0] q_dsta,
   output logic              hazard,
   output logic              ld_full,
   output logic              err,
   output logic [REG_AW-1:0] dsta,
   output logic [REG_DW-1:0] dstwd,
   output logic              dstrwen_n,
   output logic [REG_AW-1:0] srca,
   output logic [REG_DW-1:0] srcwd,
   output logic              srcrwen_n
`ifdef GPU_WB_BYPASS_EN
   ,
   output logic              byp_hit,
   output logic [REG_DW-1:0] byp_data
`endif
);

   logic [SB_ENTRIES-1:0] sb;
   logic [SB_ENTRIES-1:0] sb_n;
   reg_addr_t             q_head;
   logic                  q_full;
   logic                  q_empty;
   logic                  pop_ok;
   logic                  push_ok;
   logic                  err_ovf;
   logic                  err_unf;
   logic                  err_dbl;
   logic                  src_mask;

   // A pop frees a slot in the same cycle, so a push into a full queue is
   // legal when accompanied by a pop.
   assign pop_ok  = mem_valid & ~q_empty;
   assign push_ok = ld_issue & (~q_full | pop_ok);

   gpu_wb_ldq #(
      .DEPTH (LDQ_DEPTH)
   ) u_ldq (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .din   (ld_wa),
      .pop   (pop_ok),
      .head  (q_head),
      .full  (q_full),
      .empty (q_empty)
   );

   assign ld_full = q_full;

   // Clear first, then set: a push and pop of the same address leaves the
   // bit set for the newly queued load.
   always_comb begin
      sb_n = sb;
      if (pop_ok)  sb_n[q_head] = 1'b0;
      if (push_ok) sb_n[ld_wa]  = 1'b1;
   end

   assign err_ovf = ld_issue & q_full & ~pop_ok;
   assign err_unf = mem_valid & q_empty;
   // An issue to an address whose pending entry is popping this same cycle
   // is a plain replacement, not a double-pending load.
   assign err_dbl = ld_issue & sb[ld_wa] & ~(pop_ok & (q_head == ld_wa));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sb  <= '0;
         err <= 1'b0;
      end else begin
         sb <= sb_n;
         if (err_ovf | err_unf | err_dbl) err <= 1'b1;
      end
   end

   // Register-file write ports; address/data hold between writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dstrwen_n <= 1'b1;
         dsta      <= '0;
         dstwd     <= '0;
         srcrwen_n <= 1'b1;
         srca      <= '0;
         srcwd     <= '0;
      end else begin
         dstrwen_n <= ~alu_we;
         if (alu_we) begin
            dsta  <= alu_wa;
            dstwd <= alu_wd;
         end
         srcrwen_n <= ~pop_ok;
         if (pop_ok) begin
            srca  <= q_head;
            srcwd <= mem_data;
         end
      end
   end

`ifdef GPU_WB_BYPASS_EN
   assign byp_hit  = pop_ok & (q_head == q_srca);
   assign byp_data = mem_data;
   assign src_mask = byp_hit;
`else
   assign src_mask = 1'b0;
`endif

   assign hazard = (sb[q_srca] & ~src_mask) | sb[q_dsta];

endmodule

// File: tb/tb_gpu_wback_ctl.sv
// tb_gpu_wback_ctl: directed self-checking bench for gpu_wback_ctl.
// Inputs change 1 time unit after a rising edge; registered outputs are
// checked at that same point, combinational hazard after a further #1.
module tb_gpu_wback_ctl;
   import gpu_wb_pkg::*;

   logic              clk;
   logic              reset;
   logic              alu_we;
   logic [REG_AW-1:0] alu_wa;
   logic [REG_DW-1:0] alu_wd;
   logic              ld_issue;
   logic [REG_AW-1:0] ld_wa;
   logic              mem_valid;
   logic [REG_DW-1:0] mem_data;
   logic [REG_AW-1:0] q_srca;
   logic [REG_AW-1:0] q_dsta;
   logic              hazard;
   logic              ld_full;
   logic              err;
   logic [REG_AW-1:0] dsta;
   logic [REG_DW-1:0] dstwd;
   logic              dstrwen_n;
   logic [REG_AW-1:0] srca;
   logic [REG_DW-1:0] srcwd;
   logic              srcrwen_n;
`ifdef GPU_WB_BYPASS_EN
   logic              byp_hit;
   logic [REG_DW-1:0] byp_data;
`endif

   int passed = 0;
   int total  = 0;

   gpu_wback_ctl #(
      .LDQ_DEPTH (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_we    (alu_we),
      .alu_wa    (alu_wa),
      .alu_wd    (alu_wd),
      .ld_issue  (ld_issue),
      .ld_wa     (ld_wa),
      .mem_valid (mem_valid),
      .mem_data  (mem_data),
      .q_srca    (q_srca),
      .q_dsta    (q_dsta),
      .hazard    (hazard),
      .ld_full   (ld_full),
      .err       (err),
      .dsta      (dsta),
      .dstwd     (dstwd),
      .dstrwen_n (dstrwen_n),
      .srca      (srca),
      .srcwd     (srcwd),
      .srcrwen_n (srcrwen_n)
`ifdef GPU_WB_BYPASS_EN
      ,
      .byp_hit   (byp_hit),
      .byp_data  (byp_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      alu_we    = 1'b0;
      alu_wa    = '0;
      alu_wd    = '0;
      ld_issue  = 1'b0;
      ld_wa     = '0;
      mem_valid = 1'b0;
      mem_data  = '0;
      q_srca    = '0;
      q_dsta    = '0;
      step();
      step();

      // Reset state
      check("rst_dstrwen_n", dstrwen_n, 1);
      check("rst_srcrwen_n", srcrwen_n, 1);
      check("rst_dsta", dsta, 0);
      check("rst_dstwd", dstwd, 0);
      check("rst_srca", srca, 0);
      check("rst_srcwd", srcwd, 0);
      check("rst_ld_full", ld_full, 0);
      check("rst_err", err, 0);
      check("rst_hazard", hazard, 0);
      reset = 1'b0;
      step();

      // ALU write: one cycle wide on the dst port
      alu_we = 1'b1; alu_wa = 6'h05; alu_wd = 32'hDEADBEEF;
      step();
      alu_we = 1'b0;
      check("alu_dstrwen_n", dstrwen_n, 0);
      check("alu_dsta", dsta, 32'h05);
      check("alu_dstwd", dstwd, 32'hDEADBEEF);
      check("alu_srcrwen_n", srcrwen_n, 1);
      step();
      check("alu_dstrwen_n_off", dstrwen_n, 1);

      // Load 0x23 then return
      ld_issue = 1'b1; ld_wa = 6'h23;
      step();
      ld_issue = 1'b0;
      q_srca = 6'h23; q_dsta = 6'h00;
      #1 check("haz_src_23", hazard, 1);
      q_srca = 6'h00; q_dsta = 6'h23;
      #1 check("haz_dst_23", hazard, 1);
      q_srca = 6'h22; q_dsta = 6'h24;
      #1 check("haz_other", hazard, 0);
      q_srca = 6'h23; q_dsta = 6'h00;
      mem_valid = 1'b1; mem_data = 32'h12345678;
`ifdef GPU_WB_BYPASS_EN
      #1 check("byp_hit_23", byp_hit, 1);
      check("byp_haz_23", hazard, 0);
`else
      #1 check("haz_before_ret", hazard, 1);
`endif
      step();
      mem_valid = 1'b0;
      check("ret_srcrwen_n", srcrwen_n, 0);
      check("ret_srca", srca, 32'h23);
      check("ret_srcwd", srcwd, 32'h12345678);
      check("ret_dstrwen_n", dstrwen_n, 1);
      #1 check("haz_after_ret", hazard, 0);
      step();
      check("ret_srcrwen_n_off", srcrwen_n, 1);
      check("ret_err", err, 0);

      // Fill queue, overflow drops third issue
      ld_issue = 1'b1; ld_wa = 6'h01;
      step();
      ld_wa = 6'h02;
      step();
      ld_issue = 1'b0;
      check("fill_ld_full", ld_full, 1);
      check("fill_err", err, 0);
      ld_issue = 1'b1; ld_wa = 6'h03;
      step();
      ld_issue = 1'b0;
      check("ovf_err", err, 1);
      check("ovf_ld_full", ld_full, 1);
      q_srca = 6'h03;
      #1 check("ovf_haz_03", hazard, 0);
      q_srca = 6'h01;
      #1 check("ovf_haz_01", hazard, 1);

      // Push 0x04 and pop 0x01 together while full
      ld_issue = 1'b1; ld_wa = 6'h04;
      mem_valid = 1'b1; mem_data = 32'hAAAA0001;
      step();
      ld_issue = 1'b0; mem_valid = 1'b0;
      check("pp_srcrwen_n", srcrwen_n, 0);
      check("pp_srca", srca, 32'h01);
      check("pp_srcwd", srcwd, 32'hAAAA0001);
      check("pp_ld_full", ld_full, 1);
      q_srca = 6'h01;
      #1 check("pp_haz_01", hazard, 0);
      q_srca = 6'h04;
      #1 check("pp_haz_04", hazard, 1);

      // Drain in order: 0x02 then 0x04
      mem_valid = 1'b1; mem_data = 32'h0000B002;
      step();
      check("drain1_srcrwen_n", srcrwen_n, 0);
      check("drain1_srca", srca, 32'h02);
      check("drain1_srcwd", srcwd, 32'h0000B002);
      check("drain1_ld_full", ld_full, 0);
      mem_data = 32'h0000C004;
      step();
      mem_valid = 1'b0;
      check("drain2_srca", srca, 32'h04);
      check("drain2_srcwd", srcwd, 32'h0000C004);
      #1 check("drain2_haz_04", hazard, 0);
      step();
      check("drain_srcrwen_n_off", srcrwen_n, 1);

      // Reset with two pending loads
      ld_issue = 1'b1; ld_wa = 6'h07;
      step();
      ld_wa = 6'h08;
      step();
      ld_issue = 1'b0;
      check("pre_rst_full", ld_full, 1);
      reset = 1'b1;
      #1;
      q_srca = 6'h07; q_dsta = 6'h08;
      #1 check("mid_rst_haz", hazard, 0);
      check("mid_rst_full", ld_full, 0);
      check("mid_rst_err", err, 0);
      step();
      reset = 1'b0;
      check("mid_rst_srcrwen_n", srcrwen_n, 1);

      // Underflow: mem_valid on empty queue
      mem_valid = 1'b1; mem_data = 32'hFFFF0000;
      step();
      mem_valid = 1'b0;
      check("unf_srcrwen_n", srcrwen_n, 1);
      check("unf_srca", srca, 0);
      check("unf_err", err, 1);

      // Double-pending issue, then simultaneous ALU + load write
      reset = 1'b1;
      step();
      reset = 1'b0;
      ld_issue = 1'b1; ld_wa = 6'h09;
      step();
      check("dbl1_err", err, 0);
      step();
      ld_issue = 1'b0;
      check("dbl2_err", err, 1);
      q_srca = 6'h00; q_dsta = 6'h09;
      mem_valid = 1'b1; mem_data = 32'h00000909;
      alu_we = 1'b1; alu_wa = 6'h11; alu_wd = 32'h11110000;
      step();
      mem_valid = 1'b0; alu_we = 1'b0;
      check("dual_dstrwen_n", dstrwen_n, 0);
      check("dual_dsta", dsta, 32'h11);
      check("dual_srcrwen_n", srcrwen_n, 0);
      check("dual_srca", srca, 32'h09);
      #1 check("dbl_haz_cleared", hazard, 0);

`ifdef GPU_WB_BYPASS_EN
      // Bypass of returning load data to decode
      reset = 1'b1;
      step();
      reset = 1'b0;
      ld_issue = 1'b1; ld_wa = 6'h10;
      step();
      ld_issue = 1'b0;
      q_srca = 6'h10; q_dsta = 6'h00;
      #1 check("byp_pre_haz", hazard, 1);
      check("byp_pre_hit", byp_hit, 0);
      mem_valid = 1'b1; mem_data = 32'hA5A5A5A5;
      #1 check("byp_hit", byp_hit, 1);
      check("byp_data", byp_data, 32'hA5A5A5A5);
      check("byp_hazard", hazard, 0);
      step();
      mem_valid = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
